random_stim_misr_harness: RTL and testbench

// Parametrised OOC stimulus/compaction harness for bitstream builds: N_CH Galois-LFSR channels drive DUT inputs
// (e.g. aes128 state/key), DUT results are compacted into a SIG_W-bit MISR signature so Vivado cannot prune logic
// and pin count stays small. Adds burst/free-run control, seed reload, DUT-latency tracking and a done flag.

---
 rtl/random_stim_misr_harness.sv | 165 ++++++++++++++++
 tb/tb_random_stim_misr_harness.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/random_stim_misr_harness.sv
// Stimulus/compaction harness: Galois-LFSR channels feed a DUT, whose results are
// folded into a MISR signature. Burst or free-run issue, drain tracking, done flag.
module random_stim_misr_harness #(
    parameter int unsigned W           = 128,
    parameter int unsigned N_CH        = 2,
    parameter logic [W-1:0] POLY       = 'h87,
    parameter int unsigned SEED_BASE   = 3,
    parameter int unsigned SEED_STRIDE = 14,
    parameter int unsigned RES_W       = 128,
    parameter int unsigned SIG_W       = 32,
    parameter logic [SIG_W-1:0] MISR_POLY = SIG_W'(32'h04C11DB7),
    parameter logic [SIG_W-1:0] MISR_SEED = SIG_W'(32'hFFFFFFFF),
    parameter int unsigned DUT_LATENCY = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      burst_len,
    output logic [N_CH*W-1:0]     stim,
    output logic                  stim_valid,
    input  logic [RES_W-1:0]      dut_result,
    output logic [SIG_W-1:0]      signature,
    output logic [CNT_W-1:0]      vec_count,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned STIM_W  = N_CH * W;
    localparam int unsigned N_SLICE = RES_W / SIG_W;
    localparam int unsigned DRAIN_W = $clog2(DUT_LATENCY + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    // Per-channel seeds; a zero seed would lock the LFSR, so it becomes 1.
    function automatic logic [STIM_W-1:0] seed_vec();
        logic [STIM_W-1:0] v;
        logic [W-1:0]      s;
        v = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            s = W'(SEED_BASE) + W'(c) * W'(SEED_STRIDE);
            if (s == '0) s = W'(1);
            v[c*W +: W] = s;
        end
        return v;
    endfunction

    // One Galois step on every channel.
    function automatic logic [STIM_W-1:0] lfsr_step(input logic [STIM_W-1:0] v);
        logic [STIM_W-1:0] n;
        logic [W-1:0]      s;
        n = '0;
        for (int c = 0; c < int'(N_CH); c++) begin
            s = v[c*W +: W];
            n[c*W +: W] = {s[W-2:0], 1'b0} ^ (s[W-1] ? POLY : '0);
        end
        return n;
    endfunction

    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s);
        return {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? MISR_POLY : '0);
    endfunction

    function automatic logic [SIG_W-1:0] fold(input logic [RES_W-1:0] r);
        logic [SIG_W-1:0] f;
        f = '0;
        for (int i = 0; i < int'(N_SLICE); i++) f ^= r[i*SIG_W +: SIG_W];
        return f;
    endfunction

    localparam logic [STIM_W-1:0] SEEDS = seed_vec();

    state_t                 state_q, state_d;
    logic [STIM_W-1:0]      lfsr_q, lfsr_d;
    logic                   valid_q, valid_d;
    logic [SIG_W-1:0]       sig_q, sig_d;
    logic [CNT_W-1:0]       vec_q, vec_d;
    logic [CNT_W-1:0]       burst_q, burst_d;
    logic [DUT_LATENCY-1:0] vdl_q, vdl_d;
    logic [DRAIN_W-1:0]     drain_q, drain_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   last_vec;

    // Next-state, counters, LFSR advance and signature absorption.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        sig_d   = sig_q;
        vec_d   = vec_q;
        burst_d = burst_q;
        drain_d = drain_q;
        last_vec = (burst_q != '0) && (vec_q == burst_q - CNT_W'(1));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    lfsr_d  = SEEDS;
                    sig_d   = MISR_SEED;
                    vec_d   = '0;
                    burst_d = burst_len;
                end
            end
            S_RUN: begin
                vec_d = vec_q + CNT_W'(1);
                if (last_vec || stop) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                end
            end
            S_DRAIN: begin
                drain_d = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_W'(DUT_LATENCY - 1)) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // Delay line tail is empty in IDLE/DONE, so this never collides with a start reload.
        if (vdl_q[DUT_LATENCY-1]) sig_d = misr_step(sig_q) ^ fold(dut_result);

        vdl_d   = DUT_LATENCY'({vdl_q, valid_q});
        valid_d = (state_d == S_RUN);
        busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEEDS;
            valid_q <= 1'b0;
            sig_q   <= MISR_SEED;
            vec_q   <= '0;
            burst_q <= '0;
            vdl_q   <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            valid_q <= valid_d;
            sig_q   <= sig_d;
            vec_q   <= vec_d;
            burst_q <= burst_d;
            vdl_q   <= vdl_d;
            drain_q <= drain_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign stim       = lfsr_q;
    assign stim_valid = valid_q;
    assign signature  = sig_q;
    assign vec_count  = vec_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_random_stim_misr_harness.sv
// Directed bench: two harness instances (latency 1 single channel, latency 3 dual channel).
module tb_random_stim_misr_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: W=8, one channel, latency 1
    logic        reset0, start0, stop0;
    logic [15:0] burst0;
    logic [7:0]  stim0;
    logic        valid0;
    logic [63:0] res0;
    logic [31:0] sig0;
    logic [15:0] vec0;
    logic        busy0, done0;

    // Instance 1: W=8, two channels, latency 3
    logic        reset1, start1, stop1;
    logic [15:0] burst1;
    logic [15:0] stim1;
    logic        valid1;
    logic [63:0] res1;
    logic [31:0] sig1;
    logic [15:0] vec1;
    logic        busy1, done1;

    random_stim_misr_harness #(
        .W(8), .N_CH(1), .POLY(8'h1D), .SEED_BASE(1), .SEED_STRIDE(14),
        .RES_W(64), .SIG_W(32), .DUT_LATENCY(1), .CNT_W(16)
    ) u_dut0 (
        .clk(clk), .reset(reset0), .start(start0), .stop(stop0), .burst_len(burst0),
        .stim(stim0), .stim_valid(valid0), .dut_result(res0), .signature(sig0),
        .vec_count(vec0), .busy(busy0), .done(done0)
    );

    random_stim_misr_harness #(
        .W(8), .N_CH(2), .POLY(8'h1D), .SEED_BASE(1), .SEED_STRIDE(14),
        .RES_W(64), .SIG_W(32), .DUT_LATENCY(3), .CNT_W(16)
    ) u_dut1 (
        .clk(clk), .reset(reset1), .start(start1), .stop(stop1), .burst_len(burst1),
        .stim(stim1), .stim_valid(valid1), .dut_result(res1), .signature(sig1),
        .vec_count(vec1), .busy(busy1), .done(done1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference MISR: CRC-32 polynomial, shift left, feedback on MSB.
    function automatic logic [31:0] misr_ref(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0);
    endfunction

    function automatic logic [31:0] sig_after(input int n, input logic [31:0] k);
        logic [31:0] s;
        s = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) s = misr_ref(s) ^ k;
        return s;
    endfunction

    // x^8+x^4+x^3+x^2+1 sequence from seed 01
    logic [7:0]  exp_stim [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                   8'h20, 8'h40, 8'h80, 8'h1D, 8'h3A};
    // 64'h12345678_9ABCDEF0 folded: 12345678 ^ 9ABCDEF0
    localparam logic [31:0] K1 = 32'h88888888;
    logic [31:0] sig_first;

    initial begin
        reset0 = 1'b1; start0 = 1'b0; stop0 = 1'b0; burst0 = '0; res0 = '0;
        reset1 = 1'b1; start1 = 1'b0; stop1 = 1'b0; burst1 = '0;
        res1 = 64'h12345678_9ABCDEF0;
        tick(); tick();

        // Reset values
        check("rst_stim", 64'(stim0), 64'h01);
        check("rst_valid", 64'(valid0), 64'h0);
        check("rst_sig", 64'(sig0), 64'hFFFFFFFF);
        check("rst_busy", 64'(busy0), 64'h0);
        check("rst_done", 64'(done0), 64'h0);
        check("rst_vec", 64'(vec0), 64'h0);
        check("rst_stim1", 64'(stim1), 64'h0F01);
        reset0 = 1'b0; reset1 = 1'b0;
        tick();
        check("idle_busy", 64'(busy0), 64'h0);

        // Burst of 10, zero results
        burst0 = 16'd10; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("run_sig_init", 64'(sig0), 64'hFFFFFFFF);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("burst_stim%0d", i), 64'(stim0), 64'(exp_stim[i]));
            check($sformatf("burst_valid%0d", i), 64'(valid0), 64'h1);
            check($sformatf("burst_vec%0d", i), 64'(vec0), 64'(i));
            tick();
        end
        check("drain_valid", 64'(valid0), 64'h0);
        check("drain_busy", 64'(busy0), 64'h1);
        check("drain_done", 64'(done0), 64'h0);
        check("drain_stim_hold", 64'(stim0), 64'h3A);
        tick();
        check("burst_done", 64'(done0), 64'h1);
        check("burst_busy", 64'(busy0), 64'h0);
        check("burst_vec", 64'(vec0), 64'd10);
        check("burst_sig", 64'(sig0), 64'(sig_after(10, 32'h0)));
        sig_first = sig0;
        stop0 = 1'b1;
        tick(); tick();
        stop0 = 1'b0;
        check("done_stop_ignored", 64'(done0), 64'h1);
        check("done_sig_stable", 64'(sig0), 64'(sig_first));

        // Repeat run reproduces signature
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (11) tick();
        check("rerun_done", 64'(done0), 64'h1);
        check("rerun_sig", 64'(sig0), 64'(sig_first));

        // Free-run, stop in 5th cycle
        burst0 = 16'd0; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("free_valid%0d", i), 64'(valid0), 64'h1);
            check($sformatf("free_vec%0d", i), 64'(vec0), 64'(i));
            if (i == 4) stop0 = 1'b1;
            tick();
        end
        stop0 = 1'b0;
        check("free_drain_valid", 64'(valid0), 64'h0);
        check("free_drain_vec", 64'(vec0), 64'd5);
        tick();
        check("free_done", 64'(done0), 64'h1);
        check("free_sig", 64'(sig0), 64'(sig_after(5, 32'h0)));

        // stop+start together in DONE: restart only
        burst0 = 16'd3; start0 = 1'b1; stop0 = 1'b1;
        tick();
        start0 = 1'b0; stop0 = 1'b0;
        check("ss_busy", 64'(busy0), 64'h1);
        check("ss_valid", 64'(valid0), 64'h1);
        check("ss_vec", 64'(vec0), 64'h0);
        check("ss_stim", 64'(stim0), 64'h01);
        tick(); tick(); tick();
        check("ss_drain_vec", 64'(vec0), 64'd3);
        check("ss_drain_valid", 64'(valid0), 64'h0);
        tick();
        check("ss_done", 64'(done0), 64'h1);

        // Start ignored in RUN, then reset mid-run at vec_count 3
        burst0 = 16'd10; start0 = 1'b1;
        tick();
        start0 = 1'b0;
        tick();
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        check("run_start_ignored", 64'(vec0), 64'd2);
        tick();
        check("pre_reset_vec", 64'(vec0), 64'd3);
        reset0 = 1'b1;
        tick();
        reset0 = 1'b0;
        check("mid_rst_stim", 64'(stim0), 64'h01);
        check("mid_rst_valid", 64'(valid0), 64'h0);
        check("mid_rst_sig", 64'(sig0), 64'hFFFFFFFF);
        check("mid_rst_vec", 64'(vec0), 64'h0);
        check("mid_rst_busy", 64'(busy0), 64'h0);
        check("mid_rst_done", 64'(done0), 64'h0);
        tick();
        check("mid_rst_idle", 64'(busy0), 64'h0);

        // Dual channel, latency 3, constant nonzero result
        burst1 = 16'd6; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("ch_stim0", 64'(stim1), 64'h0F01);
        tick();
        check("ch_stim1", 64'(stim1), 64'h1E02);
        repeat (5) tick();
        check("l3_drain_valid", 64'(valid1), 64'h0);
        check("l3_drain_busy", 64'(busy1), 64'h1);
        check("l3_vec", 64'(vec1), 64'd6);
        check("l3_sig_drain0", 64'(sig1), 64'(sig_after(3, K1)));
        tick(); tick();
        check("l3_drain_done", 64'(done1), 64'h0);
        check("l3_drain_busy2", 64'(busy1), 64'h1);
        tick();
        check("l3_done", 64'(done1), 64'h1);
        check("l3_sig", 64'(sig1), 64'(sig_after(6, K1)));
        tick(); tick();
        check("l3_sig_stable", 64'(sig1), 64'(sig_after(6, K1)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
